bus_arbiter_2m: RTL and testbench



---
 rtl/bus_arbiter_2m.sv | 86 ++++++++
 tb/tb_bus_arbiter_2m.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_2m.sv
// Two-master bus arbiter and slave-side bus multiplexer.
// Master 0 (CPU) is the park owner; master 1 (DMA) borrows the bus on request.
// An optional hold limit hands the bus over after MAX_HOLD contended cycles.
module bus_arbiter_2m #(
  parameter int unsigned MAX_HOLD = 0   // 0 = owner keeps bus while requesting
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        M0_req,
  input  logic        M0_wr,
  input  logic [7:0]  M0_address,
  input  logic [31:0] M0_dout,
  output logic        M0_grant,
  input  logic        M1_req,
  input  logic        M1_wr,
  input  logic [7:0]  M1_address,
  input  logic [31:0] M1_dout,
  output logic        M1_grant,
  output logic [7:0]  S_address,
  output logic        S_wr,
  output logic [31:0] S_dout,
  output logic        owner
);

  localparam logic [0:0] M0_GRANT = 1'b0;
  localparam logic [0:0] M1_GRANT = 1'b1;

  localparam bit         PREEMPT   = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST = PREEMPT ? 8'(MAX_HOLD - 1) : 8'd0;

  logic [0:0] state, state_nxt;
  logic [7:0] hold_cnt;
  logic       both;
  logic       hold_expire;

  assign both        = M0_req & M1_req;
  assign hold_expire = PREEMPT && (hold_cnt == HOLD_LAST);

  // Next owner: hand over on release by the owner, or on hold-limit expiry.
  // M1 idle always parks the bus back on M0.
  always_comb begin
    state_nxt = state;
    case (state)
      M0_GRANT: if ((!M0_req && M1_req) || (both && hold_expire)) state_nxt = M1_GRANT;
      M1_GRANT: if (!M1_req || (both && hold_expire))             state_nxt = M0_GRANT;
      default:  state_nxt = M0_GRANT;
    endcase
  end

  // Ownership register; async reset parks the bus on M0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= M0_GRANT;
    else          state <= state_nxt;
  end

  // Contended-cycle counter: counts only while both request and nobody moves;
  // stuck at zero when preemption is disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         hold_cnt <= 8'd0;
    else if (!PREEMPT)                    hold_cnt <= 8'd0;
    else if (state_nxt != state || !both) hold_cnt <= 8'd0;
    else if (hold_cnt != 8'hFF)           hold_cnt <= hold_cnt + 8'd1;
  end

  assign M0_grant = (state == M0_GRANT);
  assign M1_grant = (state == M1_GRANT);
  assign owner    = (state == M1_GRANT);

  // Steer the owner's request onto the slave bus; a non-requesting owner
  // drives all zeros so it can never issue a stray write.
  always_comb begin
    S_address = 8'h00;
    S_wr      = 1'b0;
    S_dout    = 32'h0;
    if (owner && M1_req) begin
      S_address = M1_address;
      S_wr      = M1_wr;
      S_dout    = M1_dout;
    end else if (!owner && M0_req) begin
      S_address = M0_address;
      S_wr      = M0_wr;
      S_dout    = M0_dout;
    end
  end

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// Directed bench for bus_arbiter_2m: one instance with MAX_HOLD=0 and one
// with MAX_HOLD=4 (own request lines, shared data/reset).
module tb_bus_arbiter_2m;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [7:0]  m0_addr, m1_addr;
  logic [31:0] m0_dout, m1_dout;
  logic        p0_req, p1_req;

  logic        g0, g1, own, s_wr;
  logic [7:0]  s_addr;
  logic [31:0] s_dout;
  logic        q0, q1, qown, q_wr;
  logic [7:0]  q_addr;
  logic [31:0] q_dout;

  int nvec = 0;
  int errs = 0;

  always #5 clk = ~clk;

  bus_arbiter_2m #(.MAX_HOLD(0)) dut (
    .clk(clk), .reset_n(reset_n),
    .M0_req(m0_req), .M0_wr(m0_wr), .M0_address(m0_addr), .M0_dout(m0_dout), .M0_grant(g0),
    .M1_req(m1_req), .M1_wr(m1_wr), .M1_address(m1_addr), .M1_dout(m1_dout), .M1_grant(g1),
    .S_address(s_addr), .S_wr(s_wr), .S_dout(s_dout), .owner(own)
  );

  bus_arbiter_2m #(.MAX_HOLD(4)) dut4 (
    .clk(clk), .reset_n(reset_n),
    .M0_req(p0_req), .M0_wr(m0_wr), .M0_address(m0_addr), .M0_dout(m0_dout), .M0_grant(q0),
    .M1_req(p1_req), .M1_wr(m1_wr), .M1_address(m1_addr), .M1_dout(m1_dout), .M1_grant(q1),
    .S_address(q_addr), .S_wr(q_wr), .S_dout(q_dout), .owner(qown)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // advance past the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic exp_q1;

  initial begin
    reset_n = 1'b0;
    m0_req = 0; m0_wr = 0; m0_addr = 8'h11; m0_dout = 32'h12345678;
    m1_req = 1; m1_wr = 1; m1_addr = 8'h3C; m1_dout = 32'hDEADBEEF;
    p0_req = 0; p1_req = 0;

    // reset with M1 requesting a write: bus parked on idle M0
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_g0",   32'(g0),     32'd1);
      chk("rst_g1",   32'(g1),     32'd0);
      chk("rst_own",  32'(own),    32'd0);
      chk("rst_swr",  32'(s_wr),   32'd0);
      chk("rst_sadr", 32'(s_addr), 32'h00);
      chk("rst_sdout", s_dout,     32'h0);
    end

    // release reset, idle two cycles, then M1 requests
    m1_req = 0;
    reset_n = 1'b1;
    tick();
    tick();
    m1_req = 1; #1;
    chk("req_pre_g1",  32'(g1),   32'd0);
    chk("req_pre_swr", 32'(s_wr), 32'd0);
    chk("req_pre_adr", 32'(s_addr), 32'h00);
    tick();
    chk("m1_g1",   32'(g1),     32'd1);
    chk("m1_g0",   32'(g0),     32'd0);
    chk("m1_own",  32'(own),    32'd1);
    chk("m1_sadr", 32'(s_addr), 32'h3C);
    chk("m1_sdout", s_dout,     32'hDEADBEEF);
    chk("m1_swr",  32'(s_wr),   32'd1);

    // M1 drops request while still strobing write: nothing reaches the bus
    m1_req = 0; #1;
    chk("drop_swr",  32'(s_wr),   32'd0);
    chk("drop_sadr", 32'(s_addr), 32'h00);
    chk("drop_own",  32'(own),    32'd1);
    tick();
    chk("drop_g0",  32'(g0),   32'd1);
    chk("drop_g1",  32'(g1),   32'd0);
    chk("drop_swr2", 32'(s_wr), 32'd0);

    // simultaneous requests, no preemption: M0 holds 20 cycles
    m0_req = 1; m0_wr = 1; m1_req = 1;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("both_g0",  32'(g0),     32'd1);
      chk("both_g1",  32'(g1),     32'd0);
      chk("both_adr", 32'(s_addr), 32'h11);
      tick();
    end
    chk("both_dout", s_dout, 32'h12345678);
    m0_req = 0; m0_wr = 0; #1;
    chk("rel_pre_g0", 32'(g0), 32'd1);
    tick();
    chk("rel_g1",  32'(g1),     32'd1);
    chk("rel_adr", 32'(s_addr), 32'h3C);

    // MAX_HOLD=4 instance, both held: 4 cycles M0, 4 cycles M1, ...
    p0_req = 1; p1_req = 1;
    for (int k = 0; k < 20; k++) begin
      #1;
      exp_q1 = ((k / 4) % 2) == 1;
      chk("pre_q1",   32'(q1),   32'(exp_q1));
      chk("pre_q0",   32'(q0),   32'(!exp_q1));
      chk("pre_one",  32'(q0 ^ q1), 32'd1);
      chk("pre_adr",  32'(q_addr), exp_q1 ? 32'h3C : 32'h11);
      tick();
    end
    p0_req = 0; p1_req = 0;

    // mid-DMA transfer: async reset between edges
    m1_wr = 1; #1;
    chk("dma_g1",  32'(g1),   32'd1);
    chk("dma_swr", 32'(s_wr), 32'd1);
    @(negedge clk);
    reset_n = 1'b0; #1;
    chk("arst_g0",  32'(g0),   32'd1);
    chk("arst_g1",  32'(g1),   32'd0);
    chk("arst_swr", 32'(s_wr), 32'd0);
    #2 reset_n = 1'b1; #1;
    chk("arst_rel_g0", 32'(g0), 32'd1);
    tick();
    chk("regrant_g1",  32'(g1),   32'd1);
    chk("regrant_swr", 32'(s_wr), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

endmodule
